// File: rtl/frame_packetizer_pkg.sv
// Shared constants for the frame packetizer: magic words, block sizes, FSM encoding.
// No logic here beyond small helpers that pick the trailer shape.
// Trailer shape depends only on the chunk flag latched at frame start.
package frame_packetizer_pkg;

    localparam logic [31:0] LEADER_MAGIC        = 32'h4C56_3355;
    localparam logic [31:0] TRAILER_MAGIC       = 32'h5456_3355;
    localparam logic [31:0] PAYLOAD_TYPE        = 32'h0000_0001;
    localparam int          LEADER_WORDS        = 13;
    localparam int          LEADER_SIZE         = 52;
    localparam int          TRAILER_WORDS       = 8;
    localparam int          TRAILER_WORDS_CHUNK = 9;
    localparam int          TRAILER_SIZE        = 32;
    localparam int          TRAILER_SIZE_CHUNK  = 36;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LEADER  = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_TRAILER = 2'd3
    } state_e;

    function automatic logic [3:0] trailer_last(input logic chunk);
        return chunk ? 4'(TRAILER_WORDS_CHUNK - 1) : 4'(TRAILER_WORDS - 1);
    endfunction

    function automatic logic [31:0] trailer_size(input logic chunk);
        return chunk ? 32'(TRAILER_SIZE_CHUNK) : 32'(TRAILER_SIZE);
    endfunction

endpackage

// File: rtl/pkt_skid_fifo.sv
// Two-entry show-ahead buffer between the packet generator and the consumer.
// Latency: a word written in cycle N is on rd_dat with empty=0 in cycle N+1.
// Backpressure: full when both entries hold data; a write at full is taken only with a same-cycle pop.
module pkt_skid_fifo #(
    parameter int WD = 33
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_vld,
    input  logic [WD-1:0] wr_dat,
    output logic          full,
    input  logic          rd,
    output logic [WD-1:0] rd_dat,
    output logic          empty
);

    logic [WD-1:0] mem [2];
    logic          rd_ptr;
    logic          wr_ptr;
    logic [1:0]    count;
    logic          push;
    logic          pop;

    assign empty  = (count == 2'd0);
    assign full   = (count == 2'd2);
    assign pop    = rd && !empty;
    assign push   = wr_vld && (!full || pop);
    // Drive zero when empty so stale entries never leak onto the output bus.
    assign rd_dat = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/frame_packetizer.sv
// Wraps a payload stream in a 13-word leader and 8-word trailer (9 with FRAME_PACKETIZER_CHUNK_EN and chunk mode).
// Latency: first leader word visible two cycles after an accepted i_frame_start; one word per cycle thereafter.
// Backpressure: leader/trailer generation and o_pix_ready stall while the 2-entry output buffer is full.
module frame_packetizer
    import frame_packetizer_pkg::*;
#(
    parameter int DATA_WD        = 32,
    parameter int REG_WD         = 32,
    parameter int PACKET_SIZE_WD = 24
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_frame_start,
    input  logic [PACKET_SIZE_WD-1:0] iv_payload_size,
    input  logic [63:0]               iv_timestamp,
    input  logic [REG_WD-1:0]         iv_size_x,
    input  logic [REG_WD-1:0]         iv_size_y,
    input  logic [REG_WD-1:0]         iv_offset_x,
    input  logic [REG_WD-1:0]         iv_offset_y,
    input  logic [REG_WD-1:0]         iv_pixel_format,
    input  logic                      i_chunkmodeactive,
    input  logic [DATA_WD-1:0]        iv_pix_data,
    input  logic                      i_pix_valid,
    output logic                      o_pix_ready,
    input  logic                      iv_fifo_rd,
    output logic [DATA_WD:0]          ov_data,
    output logic                      o_empty,
    output logic                      o_frame_drop
);

    state_e                    state, state_nxt;
    logic [3:0]                cnt, cnt_nxt;
    logic [PACKET_SIZE_WD-1:0] pay_cnt, pay_cnt_nxt;
    logic [PACKET_SIZE_WD-1:0] size_q;
    logic [63:0]               ts_q;
    logic [REG_WD-1:0]         size_x_q, size_y_q, offset_x_q, offset_y_q, pix_fmt_q;
    logic [63:0]               block_id;
    logic [63:0]               bytes;
    logic                      frame_drop;
    logic                      accept;
    logic                      bid_inc;
    logic                      wr_vld;
    logic [DATA_WD:0]          wr_dat;
    logic                      full;
    logic                      pix_ready;
    logic [DATA_WD-1:0]        leader_word;
    logic [DATA_WD-1:0]        trailer_word;
    logic                      chunk_q;

`ifdef FRAME_PACKETIZER_CHUNK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            chunk_q <= 1'b0;
        end else if (accept) begin
            chunk_q <= i_chunkmodeactive;
        end
    end
`else
    logic unused_chunk;
    assign unused_chunk = i_chunkmodeactive;
    assign chunk_q      = 1'b0;
`endif

    assign bytes        = {{(62 - PACKET_SIZE_WD){1'b0}}, size_q, 2'b00};
    assign o_pix_ready  = pix_ready;
    assign o_frame_drop = frame_drop;

    always_comb begin
        leader_word = '0;
        case (cnt)
            4'd0:    leader_word = DATA_WD'(LEADER_MAGIC);
            4'd1:    leader_word = DATA_WD'(LEADER_SIZE);
            4'd2:    leader_word = DATA_WD'(block_id[31:0]);
            4'd3:    leader_word = DATA_WD'(block_id[63:32]);
            4'd4:    leader_word = DATA_WD'(PAYLOAD_TYPE);
            4'd5:    leader_word = DATA_WD'(ts_q[31:0]);
            4'd6:    leader_word = DATA_WD'(ts_q[63:32]);
            4'd7:    leader_word = DATA_WD'(pix_fmt_q);
            4'd8:    leader_word = DATA_WD'(size_x_q);
            4'd9:    leader_word = DATA_WD'(size_y_q);
            4'd10:   leader_word = DATA_WD'(offset_x_q);
            4'd11:   leader_word = DATA_WD'(offset_y_q);
            default: leader_word = '0;
        endcase
    end

    always_comb begin
        trailer_word = '0;
        case (cnt)
            4'd0:    trailer_word = DATA_WD'(TRAILER_MAGIC);
            4'd1:    trailer_word = DATA_WD'(trailer_size(chunk_q));
            4'd2:    trailer_word = DATA_WD'(block_id[31:0]);
            4'd3:    trailer_word = DATA_WD'(block_id[63:32]);
            4'd5:    trailer_word = DATA_WD'(bytes[31:0]);
            4'd6:    trailer_word = DATA_WD'(bytes[63:32]);
            4'd7:    trailer_word = DATA_WD'(size_y_q);
            default: trailer_word = '0;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pay_cnt_nxt = pay_cnt;
        wr_vld      = 1'b0;
        wr_dat      = '0;
        pix_ready   = 1'b0;
        accept      = 1'b0;
        bid_inc     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_frame_start) begin
                    accept    = 1'b1;
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_LEADER;
                end
            end
            ST_LEADER: begin
                if (!full) begin
                    wr_vld = 1'b1;
                    wr_dat = {cnt == 4'd0, leader_word};
                    if (cnt == 4'(LEADER_WORDS - 1)) begin
                        cnt_nxt     = 4'd0;
                        pay_cnt_nxt = '0;
                        state_nxt   = (size_q == '0) ? ST_TRAILER : ST_PAYLOAD;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            ST_PAYLOAD: begin
                pix_ready = !full;
                if (i_pix_valid && pix_ready) begin
                    wr_vld = 1'b1;
                    wr_dat = {pay_cnt == '0, iv_pix_data};
                    if (pay_cnt == size_q - PACKET_SIZE_WD'(1)) begin
                        cnt_nxt   = 4'd0;
                        state_nxt = ST_TRAILER;
                    end else begin
                        pay_cnt_nxt = pay_cnt + PACKET_SIZE_WD'(1);
                    end
                end
            end
            ST_TRAILER: begin
                if (!full) begin
                    wr_vld = 1'b1;
                    wr_dat = {cnt == 4'd0, trailer_word};
                    if (cnt == trailer_last(chunk_q)) begin
                        cnt_nxt   = 4'd0;
                        bid_inc   = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            pay_cnt    <= '0;
            block_id   <= 64'd1;
            frame_drop <= 1'b0;
            size_q     <= '0;
            ts_q       <= '0;
            size_x_q   <= '0;
            size_y_q   <= '0;
            offset_x_q <= '0;
            offset_y_q <= '0;
            pix_fmt_q  <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pay_cnt    <= pay_cnt_nxt;
            frame_drop <= i_frame_start && (state != ST_IDLE);
            // Wraps naturally from all-ones to zero.
            if (bid_inc) begin
                block_id <= block_id + 64'd1;
            end
            if (accept) begin
                size_q     <= iv_payload_size;
                ts_q       <= iv_timestamp;
                size_x_q   <= iv_size_x;
                size_y_q   <= iv_size_y;
                offset_x_q <= iv_offset_x;
                offset_y_q <= iv_offset_y;
                pix_fmt_q  <= iv_pixel_format;
            end
        end
    end

    pkt_skid_fifo #(
        .WD(DATA_WD + 1)
    ) u_out_buf (
        .clk    (clk),
        .reset  (reset),
        .wr_vld (wr_vld),
        .wr_dat (wr_dat),
        .full   (full),
        .rd     (iv_fifo_rd),
        .rd_dat (ov_data),
        .empty  (o_empty)
    );

endmodule

// File: tb/tb_frame_packetizer.sv
// Directed bench for frame_packetizer: a reference model pushes every expected output word
// to a scoreboard when a frame is started; a monitor pops and compares on each consumer read.
module tb_frame_packetizer;

    localparam int DW = 32;
    localparam int RW = 32;
    localparam int PW = 24;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          i_frame_start = 1'b0;
    logic [PW-1:0] iv_payload_size = '0;
    logic [63:0]   iv_timestamp = '0;
    logic [RW-1:0] iv_size_x = '0, iv_size_y = '0, iv_offset_x = '0, iv_offset_y = '0, iv_pixel_format = '0;
    logic          i_chunkmodeactive = 1'b0;
    logic [DW-1:0] iv_pix_data = 32'hA000_0000;
    logic          i_pix_valid = 1'b0;
    logic          o_pix_ready;
    logic          iv_fifo_rd = 1'b1;
    logic [DW:0]   ov_data;
    logic          o_empty;
    logic          o_frame_drop;

    int            tests = 0;
    int            fails = 0;
    logic [DW:0]   sb [$];
    logic [DW:0]   mon_exp;
    int            words_seen = 0;
    logic [63:0]   m_bid = 64'd1;
    int            pix_idx = 0;
    bit            pix_rand = 1'b0;
    bit            rd_rand = 1'b0;
    bit            rd_low = 1'b0;
    bit            pix_will;
    bit            seen;

    always #5 clk = ~clk;

    frame_packetizer #(.DATA_WD(DW), .REG_WD(RW), .PACKET_SIZE_WD(PW)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_frame_start    (i_frame_start),
        .iv_payload_size  (iv_payload_size),
        .iv_timestamp     (iv_timestamp),
        .iv_size_x        (iv_size_x),
        .iv_size_y        (iv_size_y),
        .iv_offset_x      (iv_offset_x),
        .iv_offset_y      (iv_offset_y),
        .iv_pixel_format  (iv_pixel_format),
        .i_chunkmodeactive(i_chunkmodeactive),
        .iv_pix_data      (iv_pix_data),
        .i_pix_valid      (i_pix_valid),
        .o_pix_ready      (o_pix_ready),
        .iv_fifo_rd       (iv_fifo_rd),
        .ov_data          (ov_data),
        .o_empty          (o_empty),
        .o_frame_drop     (o_frame_drop)
    );

    // Payload source: word k of the stream is 0xA0000000 + k, advanced only on a transfer.
    initial begin
        forever begin
            @(negedge clk);
            pix_will = i_pix_valid && o_pix_ready && !reset;
            @(posedge clk);
            #1;
            if (pix_will) pix_idx++;
            i_pix_valid = pix_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            iv_pix_data = 32'hA000_0000 + 32'(pix_idx);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            iv_fifo_rd = rd_low ? 1'b0 : (rd_rand ? ($urandom_range(0, 9) < 3) : 1'b1);
        end
    end

    always @(negedge clk) begin
        if (!reset && !o_empty && iv_fifo_rd) begin
            words_seen++;
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL extra_word got=%h expected=none", ov_data);
            end
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                assert (ov_data === mon_exp) else begin
                    fails++;
                    $error("FAIL word%0d got=%h expected=%h", words_seen, ov_data, mon_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s got=%h expected=%h", tag, got, want);
        end
    endtask

    task automatic push_frame(input int n, input logic [63:0] ts, input logic [31:0] pf,
                              input logic [31:0] sx, input logic [31:0] sy,
                              input logic [31:0] ox, input logic [31:0] oy, input bit chunk);
        bit          ch;
        logic [63:0] nbytes;
        ch = chunk;
`ifndef FRAME_PACKETIZER_CHUNK_EN
        ch = 1'b0;
`endif
        nbytes = 64'(n) * 64'd4;
        sb.push_back({1'b1, 32'h4C56_3355});
        sb.push_back({1'b0, 32'd52});
        sb.push_back({1'b0, m_bid[31:0]});
        sb.push_back({1'b0, m_bid[63:32]});
        sb.push_back({1'b0, 32'd1});
        sb.push_back({1'b0, ts[31:0]});
        sb.push_back({1'b0, ts[63:32]});
        sb.push_back({1'b0, pf});
        sb.push_back({1'b0, sx});
        sb.push_back({1'b0, sy});
        sb.push_back({1'b0, ox});
        sb.push_back({1'b0, oy});
        sb.push_back({1'b0, 32'd0});
        for (int k = 0; k < n; k++) begin
            sb.push_back({k == 0, 32'hA000_0000 + 32'(pix_idx + k)});
        end
        sb.push_back({1'b1, 32'h5456_3355});
        sb.push_back({1'b0, ch ? 32'd36 : 32'd32});
        sb.push_back({1'b0, m_bid[31:0]});
        sb.push_back({1'b0, m_bid[63:32]});
        sb.push_back({1'b0, 32'd0});
        sb.push_back({1'b0, nbytes[31:0]});
        sb.push_back({1'b0, nbytes[63:32]});
        sb.push_back({1'b0, sy});
        if (ch) sb.push_back({1'b0, 32'd0});
        m_bid = m_bid + 64'd1;
    endtask

    task automatic start_frame(input int n, input logic [63:0] ts, input logic [31:0] pf,
                               input logic [31:0] sx, input logic [31:0] sy,
                               input logic [31:0] ox, input logic [31:0] oy, input bit chunk);
        iv_payload_size   = PW'(n);
        iv_timestamp      = ts;
        iv_pixel_format   = pf;
        iv_size_x         = sx;
        iv_size_y         = sy;
        iv_offset_x       = ox;
        iv_offset_y       = oy;
        i_chunkmodeactive = chunk;
        i_frame_start     = 1'b1;
        words_seen        = 0;
        push_frame(n, ts, pf, sx, sy, ox, oy, chunk);
        tick();
        i_frame_start = 1'b0;
        check("no_drop_on_accept", 64'(o_frame_drop), 64'd0);
    endtask

    task automatic drain(input string tag, input int exp_words);
        for (int i = 0; i < 3000 && sb.size() != 0; i++) tick();
        repeat (4) tick();
        check({tag, "_drained"}, 64'(sb.size()), 64'd0);
        check({tag, "_count"}, 64'(words_seen), 64'(exp_words));
    endtask

    task automatic wait_ready(input string tag);
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            tick();
            seen = o_pix_ready;
        end
        check({tag, "_reach_payload"}, 64'(seen), 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        m_bid = 64'd1;
        tick();
        tick();
        check("rst_empty", 64'(o_empty), 64'd1);
        check("rst_data", 64'(ov_data), 64'd0);
        check("rst_pix_ready", 64'(o_pix_ready), 64'd0);
        check("rst_drop", 64'(o_frame_drop), 64'd0);
        reset = 1'b0;
    endtask

    int trl_chunk;
    int abort_base;

    initial begin
`ifdef FRAME_PACKETIZER_CHUNK_EN
        trl_chunk = 9;
`else
        trl_chunk = 8;
`endif
        do_reset();

        // Basic frame: 4 payload words, continuous read.
        start_frame(4, 64'h1122_3344_5566_7788, 32'h0108_0001, 32'd640, 32'd480, 32'h10, 32'h20, 1'b0);
        drain("p4", 25);

        // Empty payload: leader straight into trailer.
        start_frame(0, 64'hDEAD_BEEF_0000_0001, 32'h0110_0003, 32'd16, 32'd8, 32'd0, 32'd0, 1'b0);
        drain("p0", 21);

        // Chunk request: trailer shape depends on the build option.
        start_frame(3, 64'h0, 32'h0108_0001, 32'd32, 32'd2, 32'd1, 32'd1, 1'b1);
        drain("chunk", 13 + 3 + trl_chunk);

        // Start during payload is dropped with a single pulse.
        pix_rand = 1'b1;
        start_frame(20, 64'h55, 32'h0108_0001, 32'd100, 32'd50, 32'd0, 32'd0, 1'b0);
        wait_ready("drop");
        iv_payload_size = PW'(7);
        iv_size_y       = 32'd999;
        i_frame_start   = 1'b1;
        tick();
        i_frame_start = 1'b0;
        check("drop_pulse", 64'(o_frame_drop), 64'd1);
        tick();
        check("drop_once", 64'(o_frame_drop), 64'd0);
        drain("drop", 41);

        // Random read and valid duty: same sequence as continuous reads.
        rd_rand = 1'b1;
        start_frame(12, 64'hABCD, 32'h0108_0001, 32'd8, 32'd3, 32'd4, 32'd5, 1'b0);
        drain("rand12", 33);
        start_frame(4, 64'h1122_3344_5566_7788, 32'h0108_0001, 32'd640, 32'd480, 32'h10, 32'h20, 1'b0);
        drain("rand4", 25);
        rd_rand  = 1'b0;
        pix_rand = 1'b0;

        // Consumer stalls in payload: ready must drop once the buffer fills.
        start_frame(10, 64'h77, 32'h0108_0001, 32'd10, 32'd1, 32'd0, 32'd0, 1'b0);
        wait_ready("stall");
        rd_low = 1'b1;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            check("stall_ready_low", 64'(o_pix_ready), 64'd0);
            tick();
        end
        rd_low = 1'b0;
        drain("stall", 31);

        // Abort mid-payload; the next frame reuses the aborted block id.
        do_reset();
        start_frame(100, 64'h9, 32'h0108_0001, 32'd100, 32'd1, 32'd0, 32'd0, 1'b0);
        abort_base = pix_idx;
        for (int i = 0; i < 300 && pix_idx < abort_base + 2; i++) tick();
        check("abort_reached_word2", 64'(pix_idx >= abort_base + 2), 64'd1);
        do_reset();
        start_frame(2, 64'hA, 32'h0108_0001, 32'd2, 32'd1, 32'd0, 32'd0, 1'b0);
        drain("after_abort", 23);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_packetizer.md
FRAME_PACKETIZER -- requirements
Module: frame_packetizer

Interface
REQ-001 SHALL have parameter DATA_WD, default 32, meaning output word width excluding the flag bit.
REQ-002 SHALL have parameter REG_WD, default 32, meaning register width.
REQ-003 SHALL have parameter PACKET_SIZE_WD, default 24, meaning payload size width in 4-byte words.
REQ-004 SHALL have port clk  in  1  single clock, shared with the downstream u3 interface.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset in the clk domain.
REQ-006 SHALL have port i_frame_start  in  1  one-cycle pulse requesting a new frame.
REQ-007 SHALL have port iv_payload_size  in  PACKET_SIZE_WD  payload words for the frame, latched at an accepted i_frame_start.
REQ-008 SHALL have port iv_timestamp  in  64  frame timestamp, latched at an accepted i_frame_start.
REQ-009 SHALL have ports iv_size_x, iv_size_y, iv_offset_x, iv_offset_y, iv_pixel_format, each  in  REG_WD  image geometry and format, latched at an accepted i_frame_start.
REQ-010 SHALL have port i_chunkmodeactive  in  1  chunk enable, latched at an accepted i_frame_start.
REQ-011 SHALL have ports iv_pix_data  in  DATA_WD, i_pix_valid  in  1, and o_pix_ready  out  1, forming a payload word stream from the frame buffer read side.
REQ-012 SHALL have port iv_fifo_rd  in  1  pop request from the consumer.
REQ-013 SHALL have port ov_data  out  DATA_WD+1  show-ahead word; bit DATA_WD is the packet-start marker.
REQ-014 SHALL have port o_empty  out  1  high when no word is available.
REQ-015 SHALL have port o_frame_drop  out  1  one-cycle pulse when an i_frame_start is rejected.

Function
REQ-016 SHALL implement the FSM IDLE -> LEADER -> PAYLOAD -> TRAILER -> IDLE; i_frame_start is accepted only in IDLE.
REQ-017 SHALL, on i_frame_start outside IDLE, ignore the request and pulse o_frame_drop on the next cycle.
REQ-018 SHALL emit exactly 13 leader words in LEADER: 0x4C563355, 52, block_id[31:0], block_id[63:32], payload_type 0x0001, ts[31:0], ts[63:32], pixel_format, size_x, size_y, offset_x, offset_y, 0.
REQ-019 SHALL, in PAYLOAD, forward exactly the latched payload-size words; o_pix_ready = PAYLOAD state AND buffer not full; a word transfers when i_pix_valid && o_pix_ready.
REQ-020 SHALL go from LEADER directly to TRAILER when the latched payload size is 0.
REQ-021 SHALL emit 8 trailer words in TRAILER: 0x54563355, trailer size (32 or 36), block_id[31:0], block_id[63:32], status 0, valid_payload_size bytes[31:0], bytes[63:32], size_y; a 9th word (chunk layout id 0) follows when chunk mode applies.
REQ-022 SHALL set ov_data[DATA_WD]=1 only on the first word of the leader, of the payload, and of the trailer.
REQ-023 SHALL use a 2-entry output buffer: a word is written in cycle N and visible on ov_data with o_empty=0 in cycle N+1; iv_fifo_rd while o_empty=1 is ignored; simultaneous write and pop at full are allowed.
REQ-024 SHALL stall leader and trailer generation while the buffer is full, with no word lost or duplicated.
REQ-025 SHALL compute the byte count as the payload word count shifted left by 2, zero-extended to 64 bits.
REQ-026 SHALL keep a 64-bit block_id that starts at 1, increments on entry to IDLE from TRAILER, and wraps from all-ones to 0.

Reset
REQ-027 SHALL, on reset, set the state to IDLE, empty the buffer, set o_empty=1, ov_data=0, o_pix_ready=0, o_frame_drop=0, and block_id=1.
REQ-028 SHALL abort the frame on reset asserted mid-frame, with no trailer emitted; the next frame reuses the same block_id.

Configuration
REQ-029 SHALL, with FRAME_PACKETIZER_CHUNK_EN defined, use a 36-byte, 9-word trailer when the latched i_chunkmodeactive=1, and a 32-byte, 8-word trailer otherwise.
REQ-030 SHALL, without FRAME_PACKETIZER_CHUNK_EN, ignore i_chunkmodeactive and always use the 32-byte, 8-word trailer.

Structure
REQ-031 SHALL place the magic words, leader and trailer word counts and sizes, payload_type, and FSM state encoding in the shared package frame_packetizer_pkg.
REQ-032 SHALL implement the output buffer as the sub-module pkt_skid_fifo, with parameterised width and a fixed depth of 2.

Verification
REQ-033 SHALL cover: payload_size=4, iv_fifo_rd held high -> 13+4+8=25 words; marker on words 1, 14, and 18; word 18 = 0x54563355; word 23 = 16.
REQ-034 SHALL cover: payload_size=0 -> 21 words; leader immediately followed by the trailer; valid_payload_size=0.
REQ-035 SHALL cover: CHUNK_EN defined, chunk=1 -> trailer of 9 words; word 2 of the trailer = 36; without the macro the same stimulus -> 8 words and size 32.
REQ-036 SHALL cover: i_frame_start during PAYLOAD -> o_frame_drop pulses once; the current frame completes unchanged.
REQ-037 SHALL cover: iv_fifo_rd random 30% duty, i_pix_valid random -> output sequence identical to the continuous-read case; o_pix_ready=0 whenever the buffer is full.
REQ-038 SHALL cover: reset at payload word 2 of 100, then a new frame -> that frame's leader block_id equals the aborted frame's block_id.
